// File: rtl/regfile_wr_arb.sv
// Write-port arbiter for a single-write-port register file: round-robin between two
// writeback requesters, registered write port, and pending-write hazard reporting.
module regfile_wr_arb #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              m0_req_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic              m0_ack_o,

   input  logic              m1_req_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic              m1_ack_o,

   output logic              rf_wen_o,
   output logic [ADDR_W-1:0] rf_waddr_o,
   output logic [DATA_W-1:0] rf_wdata_o,

   input  logic [ADDR_W-1:0] chk_addr1_i,
   input  logic [ADDR_W-1:0] chk_addr2_i,
   output logic              chk_busy1_o,
   output logic              chk_busy2_o,

   output logic [31:0]       wr_cnt_o
);

   logic              m0_ack_q, m0_ack_d;
   logic              m1_ack_q, m1_ack_d;
   logic              last_q, last_d;
   logic              rf_wen_q, rf_wen_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic [31:0]       wr_cnt_q, wr_cnt_d;

   logic elig0, elig1;
   logic gnt0, gnt1;

   // A requester whose ack is high this cycle still holds req; mask it so it is not
   // granted twice. last_q = 1 means m1 was granted most recently.
   always_comb begin
      elig0 = m0_req_i & ~m0_ack_q;
      elig1 = m1_req_i & ~m1_ack_q;
      gnt0  = elig0 & (~elig1 | last_q);
      gnt1  = elig1 & (~elig0 | ~last_q);
   end

   always_comb begin
      m0_ack_d   = gnt0;
      m1_ack_d   = gnt1;
      last_d     = last_q;
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (gnt0) begin
         last_d     = 1'b0;
         rf_waddr_d = m0_addr_i;
         rf_wdata_d = m0_data_i;
         rf_wen_d   = (m0_addr_i != '0);
      end else if (gnt1) begin
         last_d     = 1'b1;
         rf_waddr_d = m1_addr_i;
         rf_wdata_d = m1_data_i;
         rf_wen_d   = (m1_addr_i != '0);
      end
      wr_cnt_d = wr_cnt_q + {31'b0, rf_wen_q};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
         last_q     <= 1'b1;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wr_cnt_q   <= '0;
      end else begin
         m0_ack_q   <= m0_ack_d;
         m1_ack_q   <= m1_ack_d;
         last_q     <= last_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   // The write being acked this cycle is excluded; the issue pipeline covers it.
   always_comb begin
      chk_busy1_o = (chk_addr1_i != '0) &
                    ((elig0 & (m0_addr_i == chk_addr1_i)) |
                     (elig1 & (m1_addr_i == chk_addr1_i)));
      chk_busy2_o = (chk_addr2_i != '0) &
                    ((elig0 & (m0_addr_i == chk_addr2_i)) |
                     (elig1 & (m1_addr_i == chk_addr2_i)));
   end

   assign m0_ack_o   = m0_ack_q;
   assign m1_ack_o   = m1_ack_q;
   assign rf_wen_o   = rf_wen_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;
   assign wr_cnt_o   = wr_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed and randomized bench for regfile_wr_arb against a transaction-level model
// of the two requesters, the round-robin rule and the register file contents.
module tb_regfile_wr_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req, m1_req;
   logic [4:0]  m0_addr, m1_addr;
   logic [31:0] m0_data, m1_data;
   logic        m0_ack, m1_ack;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  chk1 = '0, chk2 = '0;
   logic        chk_busy1, chk_busy2;
   logic [31:0] wr_cnt;

   always #5 clk = ~clk;

   regfile_wr_arb #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .m0_req_i    (m0_req),
      .m0_addr_i   (m0_addr),
      .m0_data_i   (m0_data),
      .m0_ack_o    (m0_ack),
      .m1_req_i    (m1_req),
      .m1_addr_i   (m1_addr),
      .m1_data_i   (m1_data),
      .m1_ack_o    (m1_ack),
      .rf_wen_o    (rf_wen),
      .rf_waddr_o  (rf_waddr),
      .rf_wdata_o  (rf_wdata),
      .chk_addr1_i (chk1),
      .chk_addr2_i (chk2),
      .chk_busy1_o (chk_busy1),
      .chk_busy2_o (chk_busy2),
      .wr_cnt_o    (wr_cnt)
   );

   // Requester drivers
   bit        r_req [2];
   bit [4:0]  r_addr [2];
   bit [31:0] r_data [2];
   bit        done [2];
   bit        auto_en = 0;
   int        prob = 0;
   bit        fixed_addr = 0;

   assign m0_req  = r_req[0];
   assign m0_addr = r_addr[0];
   assign m0_data = r_data[0];
   assign m1_req  = r_req[1];
   assign m1_addr = r_addr[1];
   assign m1_data = r_data[1];

   // Register file built from the DUT's write port
   logic [31:0] bench_rf [32];
   always @(posedge clk) if (rf_wen === 1'b1) bench_rf[rf_waddr] <= rf_wdata;

   // Reference model state
   bit        mack [2];
   bit        mlast = 1;
   bit        mwen = 0;
   bit [4:0]  mwaddr = 0;
   bit [31:0] mwdata = 0;
   bit [31:0] mcnt = 0;
   bit [31:0] model_rf [32];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int i, input bit [4:0] a, input bit [31:0] d);
      r_req[i]  = 1;
      r_addr[i] = a;
      r_data[i] = d;
   endtask

   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         if (!mack[i]) begin
            if (done[i]) begin
               r_req[i] = 0;
               done[i]  = 0;
            end
            if (!r_req[i] && auto_en && $urandom_range(0, 99) < prob)
               issue(i, fixed_addr ? 5'(3 + i) : 5'($urandom_range(0, 7)), $urandom);
         end
         done[i] = mack[i];
      end
   endtask

   task automatic tick();
      bit e0, e1, g0, g1, b1, b2;
      int idx;
      #1;
      e0 = r_req[0] && !mack[0];
      e1 = r_req[1] && !mack[1];
      b1 = (chk1 != 0) && ((e0 && r_addr[0] == chk1) || (e1 && r_addr[1] == chk1));
      b2 = (chk2 != 0) && ((e0 && r_addr[0] == chk2) || (e1 && r_addr[1] == chk2));
      chk("busy1", {31'b0, chk_busy1}, {31'b0, b1});
      chk("busy2", {31'b0, chk_busy2}, {31'b0, b2});
      if (e0 && e1) begin
         g0 = mlast;
         g1 = !mlast;
      end else begin
         g0 = e0;
         g1 = e1;
      end
      @(posedge clk);
      #1;
      if (mwen) model_rf[mwaddr] = mwdata;
      if (rst) begin
         mack[0] = 0; mack[1] = 0; mlast = 1;
         mwen = 0; mwaddr = 0; mwdata = 0; mcnt = 0;
      end else begin
         mcnt    = mcnt + (mwen ? 1 : 0);
         mack[0] = g0;
         mack[1] = g1;
         mwen    = 0;
         if (g0 || g1) begin
            idx    = g1 ? 1 : 0;
            mwaddr = r_addr[idx];
            mwdata = r_data[idx];
            mwen   = (mwaddr != 0);
            mlast  = g1;
         end
      end
      chk("m0_ack", {31'b0, m0_ack}, {31'b0, mack[0]});
      chk("m1_ack", {31'b0, m1_ack}, {31'b0, mack[1]});
      chk("rf_wen", {31'b0, rf_wen}, {31'b0, mwen});
      chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, mwaddr});
      chk("rf_wdata", rf_wdata, mwdata);
      chk("wr_cnt", wr_cnt, mcnt);
      drive();
   endtask

   task automatic drain();
      int k = 0;
      auto_en = 0;
      while ((r_req[0] || r_req[1]) && k < 10) begin
         tick();
         k++;
      end
      chk("drain_done", {31'b0, (r_req[0] || r_req[1])}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         bench_rf[i] = '0;
         model_rf[i] = '0;
      end

      // Reset held with m0 requesting: nothing granted
      rst = 1;
      issue(0, 5'd9, 32'h0000_0099);
      tick();
      tick();
      chk("rst_ack0", {31'b0, m0_ack}, 32'd0);
      chk("rst_wen", {31'b0, rf_wen}, 32'd0);
      chk("rst_cnt", wr_cnt, 32'd0);
      rst = 0;
      tick();
      chk("rst_first_ack", {31'b0, m0_ack}, 32'd1);
      tick();
      tick();

      // Single write
      issue(0, 5'd5, 32'hDEAD_BEEF);
      tick();
      chk("single_ack", {31'b0, m0_ack}, 32'd1);
      chk("single_wen", {31'b0, rf_wen}, 32'd1);
      chk("single_addr", {27'b0, rf_waddr}, 32'd5);
      chk("single_data", rf_wdata, 32'hDEAD_BEEF);
      tick();
      chk("single_rf5", bench_rf[5], 32'hDEAD_BEEF);
      chk("single_cnt", wr_cnt, 32'd2);

      // Contention: both continuously requesting alternate, one write per cycle
      issue(0, 5'd3, 32'h11);
      issue(1, 5'd4, 32'h22);
      auto_en = 1; prob = 100; fixed_addr = 1;
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("contend_wen", {31'b0, rf_wen}, 32'd1);
         chk("contend_one_ack", {31'b0, m0_ack ^ m1_ack}, 32'd1);
      end
      fixed_addr = 0;
      drain();
      tick();

      // r0 write: acked, not written, not counted
      issue(1, 5'd0, 32'h0000_FFFF);
      tick();
      chk("r0_ack", {31'b0, m1_ack}, 32'd1);
      chk("r0_wen", {31'b0, rf_wen}, 32'd0);
      tick();
      chk("r0_rf0", bench_rf[0], 32'd0);

      // Hazard: m1 to r7 loses the tie after reset
      rst = 1;
      tick();
      rst = 0;
      chk1 = 5'd7;
      chk2 = 5'd0;
      issue(0, 5'd3, 32'h33);
      issue(1, 5'd7, 32'h77);
      tick();
      chk("haz_m0_first", {31'b0, m0_ack}, 32'd1);
      chk("haz_busy_wait", {31'b0, chk_busy1}, 32'd1);
      tick();
      chk("haz_m1_ack", {31'b0, m1_ack}, 32'd1);
      chk("haz_busy_ack", {31'b0, chk_busy1}, 32'd0);
      chk("haz_busy2", {31'b0, chk_busy2}, 32'd0);
      drain();

      // Reset while both are eligible
      issue(0, 5'd10, 32'hA0);
      issue(1, 5'd11, 32'hB0);
      rst = 1;
      tick();
      chk("midrst_ack0", {31'b0, m0_ack}, 32'd0);
      chk("midrst_ack1", {31'b0, m1_ack}, 32'd0);
      chk("midrst_wen", {31'b0, rf_wen}, 32'd0);
      rst = 0;
      tick();
      chk("midrst_m0_wins", {31'b0, m0_ack}, 32'd1);
      drain();

      // Randomized traffic with hazard probes and occasional resets
      auto_en = 1;
      prob = 50;
      for (int i = 0; i < 3000; i++) begin
         chk1 = 5'($urandom_range(0, 7));
         chk2 = 5'($urandom_range(0, 7));
         rst  = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 0;
      drain();
      tick();
      for (int i = 0; i < 32; i++) chk("rf_final", bench_rf[i], model_rf[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
